// File: rtl/alu_acc_sequencer.sv
// Command FIFO plus accumulator front-end for the 32-bit combinational ALU.
// Commands are popped one at a time, issued for one cycle, and their result returned on a valid/ready channel.
module alu_acc_sequencer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_opcode,
   input  logic [31:0] cmd_operand,
   input  logic        cmd_use_acc,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [3:0]  alu_opcode,
   input  logic [31:0] alu_result,
   input  logic        alu_error,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_result,
   output logic        rsp_error,
   output logic [31:0] acc
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_RESPOND = 2'd2;

   localparam logic [3:0] OP_NOOP  = 4'd0;
   localparam logic [3:0] OP_RESET = 4'd1;
   localparam logic [3:0] OP_OR    = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd5;
   localparam logic [3:0] OP_ADD   = 4'd6;
   localparam logic [3:0] OP_SUB   = 4'd8;
   localparam logic [3:0] OP_EQ    = 4'd12;
   localparam logic [3:0] OP_GT    = 4'd13;
   localparam logic [3:0] OP_LT    = 4'd14;

   logic [3:0]    r_mem_op [DEPTH];
   logic [31:0]   r_mem_b  [DEPTH];
   logic          r_mem_ua [DEPTH];
   logic [AW-1:0] r_wr_ptr, r_rd_ptr;
   logic [AW:0]   r_count;
   logic [1:0]    r_state;
   logic [3:0]    r_cur_op;
   logic [31:0]   r_alu_a, r_alu_b, r_acc, r_rsp_result;
   logic [3:0]    r_alu_op;
   logic          r_rsp_error;

   logic          w_full, w_empty, w_push, w_pop, w_head_legal;
   logic [3:0]    w_head_op;
   logic [31:0]   w_cap_result, w_cap_acc;
   logic          w_cap_error;

   assign w_full    = (r_count == FULL_CNT);
   assign w_empty   = (r_count == '0);
   assign w_push    = cmd_valid && !w_full;
   assign w_pop     = !w_empty && ((r_state == S_IDLE) || ((r_state == S_RESPOND) && rsp_ready));
   assign w_head_op = r_mem_op[r_rd_ptr];

   always_comb begin
      case (w_head_op)
         OP_NOOP, OP_RESET, OP_OR, OP_AND, OP_ADD, OP_SUB, OP_EQ, OP_GT, OP_LT: w_head_legal = 1'b1;
         default: w_head_legal = 1'b0;
      endcase
   end

   // Result/accumulator selection, evaluated while the issued command's ALU output settles.
   always_comb begin
      w_cap_result = r_acc;
      w_cap_acc    = r_acc;
      w_cap_error  = 1'b0;
      case (r_cur_op)
         OP_OR, OP_AND, OP_ADD, OP_SUB: begin
            w_cap_result = alu_result;
            w_cap_acc    = alu_result;
            w_cap_error  = alu_error;
         end
         OP_EQ, OP_GT, OP_LT: begin
            w_cap_result = {31'b0, alu_result[0]};
            w_cap_error  = alu_error;
         end
         OP_NOOP: ;
         OP_RESET: begin
            w_cap_result = '0;
            w_cap_acc    = '0;
         end
         default: w_cap_error = 1'b1;
      endcase
   end

   // Storage needs no reset: emptiness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_op[r_wr_ptr] <= cmd_opcode;
         r_mem_b[r_wr_ptr]  <= cmd_operand;
         r_mem_ua[r_wr_ptr] <= cmd_use_acc;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_state      <= S_IDLE;
         r_cur_op     <= OP_NOOP;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= OP_NOOP;
         r_acc        <= '0;
         r_rsp_result <= '0;
         r_rsp_error  <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;

         if (w_pop) begin
            r_alu_a  <= r_mem_ua[r_rd_ptr] ? r_acc : '0;
            r_alu_b  <= r_mem_b[r_rd_ptr];
            r_alu_op <= w_head_legal ? w_head_op : OP_NOOP;
            r_cur_op <= w_head_op;
         end

         case (r_state)
            S_IDLE: if (w_pop) r_state <= S_ISSUE;
            S_ISSUE: begin
               r_state      <= S_RESPOND;
               r_rsp_result <= w_cap_result;
               r_rsp_error  <= w_cap_error;
               r_acc        <= w_cap_acc;
            end
            S_RESPOND: if (rsp_ready) r_state <= w_pop ? S_ISSUE : S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign cmd_ready  = !w_full;
   assign alu_a      = r_alu_a;
   assign alu_b      = r_alu_b;
   assign alu_opcode = r_alu_op;
   assign rsp_valid  = (r_state == S_RESPOND);
   assign rsp_result = r_rsp_result;
   assign rsp_error  = r_rsp_error;
   assign acc        = r_acc;

endmodule

// File: tb/tb_alu_acc_sequencer.sv
// Directed-vector bench for alu_acc_sequencer with a behavioural ALU and a response collector.
module tb_alu_acc_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [3:0]  cmd_opcode = '0;
   logic [31:0] cmd_operand = '0;
   logic        cmd_use_acc = 1'b0;
   logic [31:0] alu_a, alu_b;
   logic [3:0]  alu_opcode;
   logic [31:0] alu_result;
   logic        alu_error;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_result;
   logic        rsp_error;
   logic [31:0] acc;

   logic        err_force = 1'b0;
   int          n_vec = 0;
   int          n_miss = 0;
   int          cyc = 0;

   logic [31:0] q_res[$];
   logic [31:0] q_err[$];
   logic [31:0] q_aop[$];
   int          q_cyc[$];

   always #5 clk = ~clk;

   alu_acc_sequencer #(.DEPTH(4)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
      .cmd_operand(cmd_operand), .cmd_use_acc(cmd_use_acc),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_result(alu_result), .alu_error(alu_error),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_error(rsp_error), .acc(acc)
   );

   // Compare results carry junk in the upper bits; NOOP/RESET return junk that must be ignored.
   always_comb begin
      case (alu_opcode)
         4'd3:    alu_result = alu_a | alu_b;
         4'd5:    alu_result = alu_a & alu_b;
         4'd6:    alu_result = alu_a + alu_b;
         4'd8:    alu_result = alu_a - alu_b;
         4'd12:   alu_result = 32'hA5A4_0000 | {31'b0, alu_a == alu_b};
         4'd13:   alu_result = 32'hA5A4_0000 | {31'b0, alu_a > alu_b};
         4'd14:   alu_result = 32'hA5A4_0000 | {31'b0, alu_a < alu_b};
         4'd1:    alu_result = 32'h1234_5678;
         4'd0:    alu_result = 32'hDEAD_BEEF;
         default: alu_result = 32'hBAD0_BAD0;
      endcase
   end
   assign alu_error = err_force;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset && rsp_valid && rsp_ready) begin
         q_res.push_back(rsp_result);
         q_err.push_back({31'b0, rsp_error});
         q_aop.push_back({28'b0, alu_opcode});
         q_cyc.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end else begin
         $display("ok   %s = 0x%08h", tag, got);
      end
   endtask

   task automatic clear_q();
      q_res.delete();
      q_err.delete();
      q_aop.delete();
      q_cyc.delete();
   endtask

   function automatic logic [31:0] res_at(input int k);
      return (k < q_res.size()) ? q_res[k] : 32'hXXXX_XXXX;
   endfunction

   function automatic logic [31:0] err_at(input int k);
      return (k < q_err.size()) ? q_err[k] : 32'hXXXX_XXXX;
   endfunction

   task automatic push(input logic [3:0] op, input logic [31:0] b, input logic ua,
                       output bit ok, output int stamp);
      @(negedge clk);
      cmd_valid   = 1'b1;
      cmd_opcode  = op;
      cmd_operand = b;
      cmd_use_acc = ua;
      ok = cmd_ready;
      @(posedge clk);
      #1;
      stamp = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int n);
      for (int i = 0; i < 200 && q_res.size() < n; i++) @(posedge clk);
      #1;
      check(tag, q_res.size(), n);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 32'd1);
      check({tag, "_rsp_valid"}, {31'b0, rsp_valid}, 32'd0);
      check({tag, "_rsp_result"}, rsp_result, 32'd0);
      check({tag, "_rsp_error"}, {31'b0, rsp_error}, 32'd0);
      check({tag, "_alu_a"}, alu_a, 32'd0);
      check({tag, "_alu_b"}, alu_b, 32'd0);
      check({tag, "_alu_opcode"}, {28'b0, alu_opcode}, 32'd0);
      check({tag, "_acc"}, acc, 32'd0);
   endtask

   initial begin
      bit ok;
      int st, e0, n_acc;

      #1 reset = 1'b0;
      #3;
      check_reset_outputs("rst");
      @(negedge clk);
      reset = 1'b1;
      rsp_ready = 1'b1;

      // Chain: RESET, +65535, +2 with latency check
      clear_q();
      push(4'd1, 32'd0, 1'b0, ok, e0);
      push(4'd6, 32'd65535, 1'b1, ok, st);
      push(4'd6, 32'd2, 1'b1, ok, st);
      wait_rsp("chain_count", 3);
      check("chain_r0", res_at(0), 32'd0);
      check("chain_r1", res_at(1), 32'd65535);
      check("chain_r2", res_at(2), 32'd65537);
      check("chain_err1", err_at(1), 32'd0);
      check("chain_acc", acc, 32'd65537);
      check("chain_lat0", (q_cyc.size() > 0) ? q_cyc[0] : -1, e0 + 2);
      check("chain_lat1", (q_cyc.size() > 1) ? q_cyc[1] : -1, e0 + 4);
      check("chain_lat2", (q_cyc.size() > 2) ? q_cyc[2] : -1, e0 + 6);
      check("chain_aop1", (q_aop.size() > 1) ? q_aop[1] : 32'hX, 32'd6);

      // Subtract wrap with error passthrough
      clear_q();
      push(4'd1, 32'd0, 1'b0, ok, st);
      push(4'd6, 32'd10, 1'b0, ok, st);
      wait_rsp("sub_pre_count", 2);
      check("sub_pre_acc", acc, 32'd10);
      clear_q();
      err_force = 1'b1;
      push(4'd8, 32'd30, 1'b1, ok, st);
      wait_rsp("sub_count", 1);
      check("sub_res", res_at(0), 32'hFFFF_FFEC);
      check("sub_err", err_at(0), 32'd1);
      check("sub_acc", acc, 32'hFFFF_FFEC);
      err_force = 1'b0;

      // Compares leave acc untouched
      clear_q();
      push(4'd1, 32'd0, 1'b0, ok, st);
      push(4'd6, 32'h1FFFF, 1'b0, ok, st);
      push(4'd12, 32'h1FFFF, 1'b1, ok, st);
      push(4'd13, 32'h20000, 1'b1, ok, st);
      push(4'd14, 32'h20000, 1'b1, ok, st);
      wait_rsp("cmp_count", 5);
      check("cmp_eq", res_at(2), 32'd1);
      check("cmp_gt", res_at(3), 32'd0);
      check("cmp_lt", res_at(4), 32'd1);
      check("cmp_acc", acc, 32'h1FFFF);

      // Illegal opcode and NOOP, with the ALU error line forced high
      clear_q();
      err_force = 1'b1;
      push(4'd7, 32'd5, 1'b1, ok, st);
      push(4'd0, 32'd9, 1'b1, ok, st);
      wait_rsp("ill_count", 2);
      check("ill_res", res_at(0), 32'h1FFFF);
      check("ill_err", err_at(0), 32'd1);
      check("ill_aop", (q_aop.size() > 0) ? q_aop[0] : 32'hX, 32'd0);
      check("noop_res", res_at(1), 32'h1FFFF);
      check("noop_err", err_at(1), 32'd0);
      check("ill_acc", acc, 32'h1FFFF);
      err_force = 1'b0;

      // AND then OR on the accumulator
      clear_q();
      push(4'd5, 32'h0000_00FF, 1'b1, ok, st);
      push(4'd3, 32'h0000_0100, 1'b1, ok, st);
      wait_rsp("logic_count", 2);
      check("and_res", res_at(0), 32'h0000_00FF);
      check("or_res", res_at(1), 32'h0000_01FF);
      check("or_acc", acc, 32'h0000_01FF);

      // Backpressure: 6 offered, 5 fit (1 in RESPOND + 4 queued)
      clear_q();
      rsp_ready = 1'b0;
      n_acc = 0;
      for (int k = 1; k <= 6; k++) begin
         push(4'd6, k, 1'b0, ok, st);
         if (ok) n_acc++;
      end
      check("bp_accepted", n_acc, 32'd5);
      check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      check("bp_no_rsp", q_res.size(), 32'd0);
      rsp_ready = 1'b1;
      wait_rsp("bp_count", 5);
      for (int k = 0; k < 5; k++) check($sformatf("bp_r%0d", k), res_at(k), k + 1);
      repeat (6) @(posedge clk);
      #1;
      check("bp_no_dup", q_res.size(), 32'd5);

      // Reset asserted during ISSUE with three commands still queued
      clear_q();
      rsp_ready = 1'b0;
      n_acc = 0;
      for (int k = 1; k <= 5; k++) begin
         push(4'd6, 32'd100 + k, 1'b0, ok, st);
         if (ok) n_acc++;
      end
      check("mid_accepted", n_acc, 32'd5);
      rsp_ready = 1'b1;
      @(posedge clk);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("mid");
      clear_q();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check("mid_no_rsp", q_res.size(), 32'd0);
      check("mid_idle", {31'b0, rsp_valid}, 32'd0);
      push(4'd6, 32'd7, 1'b1, ok, st);
      wait_rsp("post_count", 1);
      check("post_res", res_at(0), 32'd7);
      check("post_acc", acc, 32'd7);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
